// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings, control bundle layout and small helpers for the
// 3-stage (ID / EX / WB) RV32I pipeline controller.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] ASEL_RS1  = 2'd0;
    localparam logic [1:0] ASEL_PC   = 2'd1;
    localparam logic [1:0] ASEL_FWD  = 2'd2;
    localparam logic [1:0] ASEL_ZERO = 2'd3;

    localparam logic [1:0] BSEL_RS2 = 2'd0;
    localparam logic [1:0] BSEL_IMM = 2'd1;
    localparam logic [1:0] BSEL_FWD = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef enum logic [2:0] {
        BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_JAL, BR_JALR
    } br_type_e;

    // An all-zero bundle is a bubble.
    typedef struct packed {
        logic       valid;
        logic [1:0] a_sel;
        logic [1:0] b_sel;
        logic [3:0] alu_sel;
        br_type_e   br_type;
        logic       br_un;
        logic       store;
        logic [1:0] st_size;
        logic       csr_wen;
        logic       csr_sel;
        logic       reg_wen;
        logic [1:0] wb_sel;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use_rs1;
        logic       use_rs2;
    } ctrl_bundle_t;

    function automatic logic [3:0] alu_decode(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // x0 is never a real dependence; only writing producers count.
    function automatic logic src_match(input logic use_rs, input logic [4:0] rs,
                                       input logic wen, input logic [4:0] rd);
        return use_rs && (rs != 5'd0) && wen && (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Controller <-> datapath signal bundle. master = controller, slave = datapath.
interface pipe_ctrl_if;
    logic        mem_stall;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        ex_br_eq;
    logic        ex_br_lt;
    logic [1:0]  alu_addr_lo;

    logic [2:0]  id_imm_sel;
    logic        id_stall;
    logic        pc_sel;
    logic        id_flush;
    logic        ex_valid;
    logic [1:0]  ex_a_sel;
    logic [1:0]  ex_b_sel;
    logic [3:0]  ex_alu_sel;
    logic        ex_br_un;
    logic [3:0]  ex_mem_wen;
    logic        ex_csr_wen;
    logic        ex_csr_sel;
    logic        wb_reg_wen;
    logic [1:0]  wb_sel;
    logic [4:0]  wb_rd;
    logic        illegal_inst;

    modport master (
        input  mem_stall, id_inst, id_valid, ex_br_eq, ex_br_lt, alu_addr_lo,
        output id_imm_sel, id_stall, pc_sel, id_flush, ex_valid, ex_a_sel, ex_b_sel,
               ex_alu_sel, ex_br_un, ex_mem_wen, ex_csr_wen, ex_csr_sel,
               wb_reg_wen, wb_sel, wb_rd, illegal_inst
    );

    modport slave (
        output mem_stall, id_inst, id_valid, ex_br_eq, ex_br_lt, alu_addr_lo,
        input  id_imm_sel, id_stall, pc_sel, id_flush, ex_valid, ex_a_sel, ex_b_sel,
               ex_alu_sel, ex_br_un, ex_mem_wen, ex_csr_wen, ex_csr_sel,
               wb_reg_wen, wb_sel, wb_rd, illegal_inst
    );
endinterface

// File: rtl/pipe_ctrl_decode.sv
// Purely combinational ID decode: instruction word -> control bundle.
// Unknown or malformed encodings raise illegal and yield a bubble.
module pipe_ctrl_decode import pipe_ctrl_pkg::*; #(
    parameter bit CSR_EN = 1'b1
) (
    input  logic [31:0]  inst,
    output ctrl_bundle_t ctrl,
    output logic [2:0]   imm_sel,
    output logic         illegal
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7_bad;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    // funct7 may only be 0000000 or 0100000
    assign f7_bad = inst[31] | (|inst[29:25]);

    // Opcode -> bundle mapping.
    always_comb begin
        ctrl     = '0;
        imm_sel  = IMM_I;
        illegal  = 1'b0;
        ctrl.rs1 = inst[19:15];
        ctrl.rs2 = inst[24:20];
        case (opcode)
            OP_LUI: begin
                imm_sel = IMM_U;  ctrl.a_sel = ASEL_ZERO; ctrl.b_sel = BSEL_IMM;
                ctrl.reg_wen = 1'b1;
            end
            OP_AUIPC: begin
                imm_sel = IMM_U;  ctrl.a_sel = ASEL_PC; ctrl.b_sel = BSEL_IMM;
                ctrl.reg_wen = 1'b1;
            end
            OP_JAL: begin
                imm_sel = IMM_J;  ctrl.a_sel = ASEL_PC; ctrl.b_sel = BSEL_IMM;
                ctrl.br_type = BR_JAL; ctrl.reg_wen = 1'b1; ctrl.wb_sel = WB_PC4;
            end
            OP_JALR: begin
                ctrl.b_sel = BSEL_IMM; ctrl.use_rs1 = 1'b1;
                ctrl.br_type = BR_JALR; ctrl.reg_wen = 1'b1; ctrl.wb_sel = WB_PC4;
                illegal = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                imm_sel = IMM_B;  ctrl.a_sel = ASEL_PC; ctrl.b_sel = BSEL_IMM;
                ctrl.use_rs1 = 1'b1; ctrl.use_rs2 = 1'b1; ctrl.br_un = funct3[1];
                case (funct3)
                    3'b000:         ctrl.br_type = BR_EQ;
                    3'b001:         ctrl.br_type = BR_NE;
                    3'b100, 3'b110: ctrl.br_type = BR_LT;
                    3'b101, 3'b111: ctrl.br_type = BR_GE;
                    default:        illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                ctrl.b_sel = BSEL_IMM; ctrl.use_rs1 = 1'b1;
                ctrl.reg_wen = 1'b1; ctrl.wb_sel = WB_MEM;
                illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OP_STORE: begin
                imm_sel = IMM_S;  ctrl.b_sel = BSEL_IMM;
                ctrl.use_rs1 = 1'b1; ctrl.use_rs2 = 1'b1;
                ctrl.store = 1'b1; ctrl.st_size = funct3[1:0];
                illegal = (funct3[2] || funct3[1:0] == 2'b11);
            end
            OP_IMM: begin
                ctrl.b_sel = BSEL_IMM; ctrl.use_rs1 = 1'b1; ctrl.reg_wen = 1'b1;
                ctrl.alu_sel = alu_decode(funct3, (funct3 == 3'b101) && inst[30]);
                illegal = (funct3 == 3'b001 && (f7_bad || inst[30])) ||
                          (funct3 == 3'b101 && f7_bad);
            end
            OP_REG: begin
                ctrl.use_rs1 = 1'b1; ctrl.use_rs2 = 1'b1; ctrl.reg_wen = 1'b1;
                ctrl.alu_sel = alu_decode(funct3, inst[30]);
                illegal = f7_bad || (inst[30] && funct3 != 3'b000 && funct3 != 3'b101);
            end
            OP_SYSTEM: begin
                // CSR read data returns on the ALU result path.
                if (CSR_EN && funct3 == 3'b001) begin
                    ctrl.csr_wen = 1'b1; ctrl.use_rs1 = 1'b1; ctrl.reg_wen = 1'b1;
                end else if (CSR_EN && funct3 == 3'b101) begin
                    ctrl.csr_wen = 1'b1; ctrl.csr_sel = 1'b1; ctrl.reg_wen = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        ctrl.rd    = ctrl.reg_wen ? inst[11:7] : 5'd0;
        ctrl.valid = 1'b1;
        if (illegal) begin
            ctrl = '0;
        end
    end
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: owns the EX/WB control registers, resolves branches
// in EX and handles RAW hazards by WB->EX forwarding or by stalling ID.
module pipe_ctrl import pipe_ctrl_pkg::*; #(
    parameter bit FWD_EN = 1'b1,
    parameter bit CSR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.master bus
);
    ctrl_bundle_t id_ctrl;
    ctrl_bundle_t ex_q;
    logic [2:0]   dec_imm_sel;
    logic         dec_illegal;
    logic         ex_illegal_q;
    logic         wb_reg_wen_q;
    logic [1:0]   wb_sel_q;
    logic [4:0]   wb_rd_q;
    logic         taken;
    logic         raw_hazard;
    logic         flush;
    logic         stall;

    pipe_ctrl_decode #(.CSR_EN(CSR_EN)) u_decode (
        .inst    (bus.id_inst),
        .ctrl    (id_ctrl),
        .imm_sel (dec_imm_sel),
        .illegal (dec_illegal)
    );

    // Branch / jump outcome of the instruction sitting in EX.
    always_comb begin
        taken = 1'b0;
        case (ex_q.br_type)
            BR_JAL, BR_JALR: taken = 1'b1;
            BR_EQ:           taken = bus.ex_br_eq;
            BR_NE:           taken = !bus.ex_br_eq;
            BR_LT:           taken = bus.ex_br_lt;
            BR_GE:           taken = !bus.ex_br_lt;
            default:         taken = 1'b0;
        endcase
    end

    // ID sources against the EX and WB producers.
    always_comb begin
        raw_hazard = 1'b0;
        if (bus.id_valid) begin
            raw_hazard = src_match(id_ctrl.use_rs1, id_ctrl.rs1, ex_q.reg_wen, ex_q.rd)  ||
                         src_match(id_ctrl.use_rs1, id_ctrl.rs1, wb_reg_wen_q, wb_rd_q)  ||
                         src_match(id_ctrl.use_rs2, id_ctrl.rs2, ex_q.reg_wen, ex_q.rd)  ||
                         src_match(id_ctrl.use_rs2, id_ctrl.rs2, wb_reg_wen_q, wb_rd_q);
        end
    end

    // A frozen pipe neither redirects nor stalls; a flush overrides a stall.
    assign flush = !bus.mem_stall && ex_q.valid && taken;
    assign stall = !FWD_EN && !bus.mem_stall && !flush && raw_hazard;

    // Stage registers: hold under mem_stall, otherwise shift with bubble insertion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q         <= '0;
            ex_illegal_q <= 1'b0;
            wb_reg_wen_q <= 1'b0;
            wb_sel_q     <= WB_ALU;
            wb_rd_q      <= 5'd0;
        end else if (!bus.mem_stall) begin
            if (bus.id_valid && !stall && !flush) begin
                ex_q         <= id_ctrl;
                ex_illegal_q <= dec_illegal;
            end else begin
                ex_q         <= '0;
                ex_illegal_q <= 1'b0;
            end
            wb_reg_wen_q <= ex_q.reg_wen;
            wb_sel_q     <= ex_q.wb_sel;
            wb_rd_q      <= ex_q.rd;
        end
    end

    // Output drive, including forwarding selects and store byte lanes.
    always_comb begin
        bus.id_imm_sel = (bus.id_valid && !rst) ? dec_imm_sel : IMM_I;
        bus.id_stall   = stall;
        bus.pc_sel     = flush;
        bus.id_flush   = flush;
        bus.ex_valid   = ex_q.valid;
        bus.ex_a_sel   = ex_q.a_sel;
        if (FWD_EN && ex_q.a_sel == ASEL_RS1 &&
            src_match(ex_q.use_rs1, ex_q.rs1, wb_reg_wen_q, wb_rd_q)) begin
            bus.ex_a_sel = ASEL_FWD;
        end
        bus.ex_b_sel = ex_q.b_sel;
        if (FWD_EN && ex_q.b_sel == BSEL_RS2 &&
            src_match(ex_q.use_rs2, ex_q.rs2, wb_reg_wen_q, wb_rd_q)) begin
            bus.ex_b_sel = BSEL_FWD;
        end
        bus.ex_alu_sel = ex_q.alu_sel;
        bus.ex_br_un   = ex_q.br_un;
        bus.ex_mem_wen = 4'b0000;
        if (ex_q.store) begin
            case (ex_q.st_size)
                2'b00:   bus.ex_mem_wen = 4'b0001 << bus.alu_addr_lo;
                2'b01:   bus.ex_mem_wen = 4'b0011 << {bus.alu_addr_lo[1], 1'b0};
                default: bus.ex_mem_wen = 4'b1111;
            endcase
        end
        bus.ex_csr_wen   = ex_q.csr_wen;
        bus.ex_csr_sel   = ex_q.csr_sel;
        bus.wb_reg_wen   = wb_reg_wen_q;
        bus.wb_sel       = wb_sel_q;
        bus.wb_rd        = wb_rd_q;
        bus.illegal_inst = ex_illegal_q;
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one forwarding/CSR instance and one
// stalling/no-CSR instance share the same stimulus.
module tb_pipe_ctrl;
    localparam logic [31:0] I_ADDI   = 32'h00200093;
    localparam logic [31:0] I_ADD    = 32'h00308133;
    localparam logic [31:0] I_BEQ    = 32'h00310863;
    localparam logic [31:0] I_BLTU   = 32'h02316063;
    localparam logic [31:0] I_SW     = 32'h00112223;
    localparam logic [31:0] I_SB     = 32'h001101A3;
    localparam logic [31:0] I_SH     = 32'h001111A3;
    localparam logic [31:0] I_JAL    = 32'h008000EF;
    localparam logic [31:0] I_CSRRWI = 32'h3002D0F3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_stall = 1'b0;
    logic [31:0] id_inst = 32'd0;
    logic        id_valid = 1'b0;
    logic        ex_br_eq = 1'b0;
    logic        ex_br_lt = 1'b0;
    logic [1:0]  alu_addr_lo = 2'd0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] out_f;
    logic [31:0] out_s;

    always #5 clk = ~clk;

    pipe_ctrl_if if_f ();
    pipe_ctrl_if if_s ();

    assign if_f.mem_stall = mem_stall;   assign if_s.mem_stall = mem_stall;
    assign if_f.id_inst = id_inst;       assign if_s.id_inst = id_inst;
    assign if_f.id_valid = id_valid;     assign if_s.id_valid = id_valid;
    assign if_f.ex_br_eq = ex_br_eq;     assign if_s.ex_br_eq = ex_br_eq;
    assign if_f.ex_br_lt = ex_br_lt;     assign if_s.ex_br_lt = ex_br_lt;
    assign if_f.alu_addr_lo = alu_addr_lo; assign if_s.alu_addr_lo = alu_addr_lo;

    pipe_ctrl #(.FWD_EN(1'b1), .CSR_EN(1'b1)) dut_f (.clk(clk), .rst(rst), .bus(if_f));
    pipe_ctrl #(.FWD_EN(1'b0), .CSR_EN(1'b0)) dut_s (.clk(clk), .rst(rst), .bus(if_s));

    assign out_f = {1'b0, if_f.id_imm_sel, if_f.id_stall, if_f.pc_sel, if_f.id_flush, if_f.ex_valid,
                    if_f.ex_a_sel, if_f.ex_b_sel, if_f.ex_alu_sel, if_f.ex_br_un, if_f.ex_mem_wen,
                    if_f.ex_csr_wen, if_f.ex_csr_sel, if_f.wb_reg_wen, if_f.wb_sel, if_f.wb_rd,
                    if_f.illegal_inst};
    assign out_s = {1'b0, if_s.id_imm_sel, if_s.id_stall, if_s.pc_sel, if_s.id_flush, if_s.ex_valid,
                    if_s.ex_a_sel, if_s.ex_b_sel, if_s.ex_alu_sel, if_s.ex_br_un, if_s.ex_mem_wen,
                    if_s.ex_csr_wen, if_s.ex_csr_sel, if_s.wb_reg_wen, if_s.wb_sel, if_s.wb_rd,
                    if_s.illegal_inst};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        id_valid = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        // reset and first cycle after it
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_f", out_f, 32'h0);
        chk("rst_out_s", out_s, 32'h0);
        rst = 1'b0;
        cyc();
        chk("post_rst_f", out_f, 32'h0);
        chk("post_rst_s", out_s, 32'h0);

        // addi -> add, forwarding instance
        id_inst = I_ADDI; id_valid = 1'b1; #1;
        chk("addi_imm_sel", 32'(if_f.id_imm_sel), 32'd0);
        cyc();
        id_inst = I_ADD; #1;
        chk("addi_ex_sel", 32'({if_f.ex_valid, if_f.ex_a_sel, if_f.ex_b_sel}), 32'b10001);
        chk("fwd_no_stall", 32'(if_f.id_stall), 32'd0);
        cyc();
        id_valid = 1'b0; #1;
        chk("fwd_a_sel", 32'(if_f.ex_a_sel), 32'd2);
        chk("fwd_b_sel", 32'(if_f.ex_b_sel), 32'd0);
        chk("fwd_wb", 32'({if_f.wb_reg_wen, if_f.wb_sel, if_f.wb_rd}), 32'h81);
        drain();

        // addi -> add, stalling instance: two bubbles
        id_inst = I_ADDI; id_valid = 1'b1; #1;
        chk("stl_s0", 32'(if_s.id_stall), 32'd0);
        cyc();
        id_inst = I_ADD; #1;
        chk("stl_s1", 32'(if_s.id_stall), 32'd1);
        cyc();
        chk("stl_s2", 32'(if_s.id_stall), 32'd1);
        chk("stl_bubble", 32'(if_s.ex_valid), 32'd0);
        cyc();
        chk("stl_s3", 32'(if_s.id_stall), 32'd0);
        cyc();
        id_valid = 1'b0; #1;
        chk("stl_add_ex", 32'({if_s.ex_valid, if_s.ex_a_sel, if_s.ex_b_sel}), 32'b10000);
        drain();

        // beq taken, with a mem_stall override, then not taken
        id_inst = I_BEQ; id_valid = 1'b1; ex_br_eq = 1'b1; #1;
        chk("beq_imm", 32'(if_f.id_imm_sel), 32'd2);
        cyc();
        id_inst = I_ADDI; #1;
        chk("beq_pc_sel", 32'(if_f.pc_sel), 32'd1);
        chk("beq_flush", 32'(if_f.id_flush), 32'd1);
        chk("beq_un", 32'(if_f.ex_br_un), 32'd0);
        mem_stall = 1'b1; #1;
        chk("beq_mstall", 32'({if_f.pc_sel, if_f.id_flush, if_f.id_stall}), 32'd0);
        mem_stall = 1'b0; #1;
        cyc();
        id_valid = 1'b0; #1;
        chk("beq_squash", 32'({if_f.ex_valid, if_f.pc_sel}), 32'd0);
        id_inst = I_BEQ; id_valid = 1'b1; ex_br_eq = 1'b0;
        cyc();
        id_valid = 1'b0; #1;
        chk("beq_nt", 32'({if_f.ex_valid, if_f.pc_sel, if_f.id_flush}), 32'b100);

        // bltu: unsigned, taken only on lt
        id_inst = I_BLTU; id_valid = 1'b1; ex_br_lt = 1'b0;
        cyc();
        id_valid = 1'b0; #1;
        chk("bltu_un", 32'(if_f.ex_br_un), 32'd1);
        chk("bltu_nt", 32'(if_f.pc_sel), 32'd0);
        ex_br_lt = 1'b1; #1;
        chk("bltu_t", 32'(if_f.pc_sel), 32'd1);
        cyc();
        ex_br_lt = 1'b0; #1;
        chk("bltu_squash", 32'(if_f.ex_valid), 32'd0);

        // sw with 3-cycle mem_stall hold, then sb / sh lanes
        id_inst = I_SW; id_valid = 1'b1; alu_addr_lo = 2'd0; #1;
        chk("sw_imm", 32'(if_f.id_imm_sel), 32'd1);
        cyc();
        id_inst = I_ADDI; #1;
        chk("sw_wen", 32'(if_f.ex_mem_wen), 32'hF);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("sw_hold_f", out_f, 32'h01107800);
            chk("sw_hold_s", out_s, 32'h01107800);
        end
        mem_stall = 1'b0; id_valid = 1'b0;
        cyc();
        chk("sw_wb", out_f, 32'h0);
        id_inst = I_SB; id_valid = 1'b1; alu_addr_lo = 2'd3;
        cyc();
        chk("sb_wen", 32'(if_f.ex_mem_wen), 32'h8);
        id_inst = I_SH; alu_addr_lo = 2'd2;
        cyc();
        id_valid = 1'b0; #1;
        chk("sh_wen", 32'(if_f.ex_mem_wen), 32'hC);
        drain();

        // csrrwi: legal with CSR_EN=1, illegal pulse with CSR_EN=0
        id_inst = I_CSRRWI; id_valid = 1'b1;
        cyc();
        id_valid = 1'b0; #1;
        chk("csr_ill_s", 32'({if_s.illegal_inst, if_s.ex_csr_wen, if_s.ex_valid}), 32'b100);
        chk("csr_f", 32'({if_f.ex_valid, if_f.ex_csr_wen, if_f.ex_csr_sel, if_f.illegal_inst}), 32'b1110);
        cyc();
        chk("csr_ill_pulse", 32'(if_s.illegal_inst), 32'd0);
        chk("csr_wen_pulse", 32'(if_f.ex_csr_wen), 32'd0);

        // async reset while jal is in EX
        id_inst = I_JAL; id_valid = 1'b1;
        cyc();
        chk("jal_imm", 32'(if_f.id_imm_sel), 32'd4);
        chk("jal_ex", 32'({if_f.ex_valid, if_f.pc_sel, if_f.ex_a_sel, if_f.ex_b_sel}), 32'b110101);
        rst = 1'b1; #1;
        chk("rst_mid_f", out_f, 32'h0);
        chk("rst_mid_s", out_s, 32'h0);
        cyc();
        rst = 1'b0; id_valid = 1'b0;
        cyc();
        chk("rst_after", out_f, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
